// File: rtl/ball_move_sched_if.sv
// Ball motion scheduler bus.
//   master : drives keycode and ball geometry, observes motion/status
//   slave  : the scheduler; consumes keycode/geometry, drives motion/status
// Signals:
//   keycode    [7:0]  HID keycode, 8'h00 = no key
//   BallX/Y    [9:0]  current ball centre
//   BallS      [9:0]  ball half-size
//   MotionX/Y  [9:0]  registered two's-complement per-frame motion
//   auto_mode         high while autopilot is active
//   fifo_count [2:0]  queued commands (0..4)
//   overflow          sticky, a command was dropped
interface ball_move_sched_if;
   logic [7:0] keycode;
   logic [9:0] BallX;
   logic [9:0] BallY;
   logic [9:0] BallS;
   logic [9:0] MotionX;
   logic [9:0] MotionY;
   logic       auto_mode;
   logic [2:0] fifo_count;
   logic       overflow;

   modport master (
      output keycode, BallX, BallY, BallS,
      input  MotionX, MotionY, auto_mode, fifo_count, overflow
   );

   modport slave (
      input  keycode, BallX, BallY, BallS,
      output MotionX, MotionY, auto_mode, fifo_count, overflow
   );
endinterface

// File: rtl/ball_move_sched.sv
// Ball motion scheduler: arrow keycodes are edge-detected and queued in a
// 4-deep command FIFO; each command drives the ball for SEG_LEN frames.
// With nothing queued the ball holds its motion, and after IDLE_TIMEOUT
// idle frames it reverts to autopilot. Wall bounce overrides every state.
// Ports:
//   frame_clk  frame-rate clock, rising edge
//   Reset      synchronous, active-high
//   bus        ball_move_sched_if.slave (keycode/ball in, motion/status out)
//
// state | meaning
// AUTO  | autopilot, motion kept except wall bounce
// LOAD  | pop head command into MotionX/MotionY, start segment
// RUN   | executing segment, seg_cnt counts down to 0
// HOLD  | queue empty, motion kept, idle_cnt counts up to timeout
module ball_move_sched #(
   parameter logic [9:0] STEP         = 10'd1,
   parameter int         SEG_LEN      = 16,
   parameter int         IDLE_TIMEOUT = 300,
   parameter int         X_MIN        = 0,
   parameter int         X_MAX        = 639,
   parameter int         Y_MIN        = 0,
   parameter int         Y_MAX        = 479
) (
   input  logic               frame_clk,
   input  logic               Reset,
   ball_move_sched_if.slave   bus
);

   typedef enum logic [1:0] {S_AUTO, S_LOAD, S_RUN, S_HOLD} state_t;

   localparam logic [1:0]  CMD_UP    = 2'd0;
   localparam logic [1:0]  CMD_DOWN  = 2'd1;
   localparam logic [1:0]  CMD_LEFT  = 2'd2;
   localparam logic [1:0]  CMD_RIGHT = 2'd3;
   localparam logic [9:0]  NEG_STEP  = ~STEP + 10'd1;
   localparam logic [15:0] SEG_LAST  = 16'(SEG_LEN - 1);
   localparam logic [15:0] IDLE_LAST = 16'(IDLE_TIMEOUT - 1);
   localparam logic [10:0] X_MIN11   = 11'(X_MIN);
   localparam logic [10:0] X_MAX11   = 11'(X_MAX);
   localparam logic [10:0] Y_MIN11   = 11'(Y_MIN);
   localparam logic [10:0] Y_MAX11   = 11'(Y_MAX);

   state_t      r_state;
   logic [9:0]  r_motion_x;
   logic [9:0]  r_motion_y;
   logic        r_auto;
   logic [7:0]  r_key_prev;
   logic [1:0]  r_fifo [4];
   logic [1:0]  r_wr_ptr;
   logic [1:0]  r_rd_ptr;
   logic [2:0]  r_count;
   logic        r_overflow;
   logic [15:0] r_seg_cnt;
   logic [15:0] r_idle_cnt;

   logic        w_key_valid;
   logic [1:0]  w_key_cmd;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_push_ok;
   logic [9:0]  w_cmd_mx;
   logic [9:0]  w_cmd_my;
   logic        w_x_hi, w_x_lo, w_y_hi, w_y_lo;

   always_comb begin
      w_key_valid = 1'b1;
      w_key_cmd   = CMD_UP;
      case (bus.keycode)
         8'h1A:   w_key_cmd = CMD_UP;
         8'h16:   w_key_cmd = CMD_DOWN;
         8'h04:   w_key_cmd = CMD_LEFT;
         8'h07:   w_key_cmd = CMD_RIGHT;
         default: w_key_valid = 1'b0;
      endcase
   end

   always_comb begin
      w_cmd_mx = 10'd0;
      w_cmd_my = 10'd0;
      case (r_fifo[r_rd_ptr])
         CMD_UP:    w_cmd_my = NEG_STEP;
         CMD_DOWN:  w_cmd_my = STEP;
         CMD_LEFT:  w_cmd_mx = NEG_STEP;
         default:   w_cmd_mx = STEP;
      endcase
   end

   // Only LOAD pops, and LOAD is only entered with a non-empty queue.
   assign w_push    = w_key_valid && (bus.keycode != r_key_prev);
   assign w_pop     = (r_state == S_LOAD) && (r_count != 3'd0);
   assign w_full    = (r_count == 3'd4);
   assign w_push_ok = w_push && (!w_full || w_pop);

   // 11-bit compares so BallX+BallS cannot wrap.
   assign w_x_hi = ({1'b0, bus.BallX} + {1'b0, bus.BallS}) >= X_MAX11;
   assign w_x_lo = {1'b0, bus.BallX} <= (X_MIN11 + {1'b0, bus.BallS});
   assign w_y_hi = ({1'b0, bus.BallY} + {1'b0, bus.BallS}) >= Y_MAX11;
   assign w_y_lo = {1'b0, bus.BallY} <= (Y_MIN11 + {1'b0, bus.BallS});

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         r_state    <= S_AUTO;
         r_motion_x <= STEP;
         r_motion_y <= 10'd0;
         r_auto     <= 1'b1;
         r_key_prev <= 8'h00;
         r_fifo     <= '{default: 2'd0};
         r_wr_ptr   <= 2'd0;
         r_rd_ptr   <= 2'd0;
         r_count    <= 3'd0;
         r_overflow <= 1'b0;
         r_seg_cnt  <= 16'd0;
         r_idle_cnt <= 16'd0;
      end else begin
         r_key_prev <= bus.keycode;

         if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= w_key_cmd;
            r_wr_ptr         <= r_wr_ptr + 2'd1;
         end
         if (w_push && !w_push_ok)
            r_overflow <= 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase

         case (r_state)
            S_AUTO: begin
               if (r_count != 3'd0) begin
                  r_state <= S_LOAD;
                  r_auto  <= 1'b0;
               end
            end
            S_LOAD: begin
               r_motion_x <= w_cmd_mx;
               r_motion_y <= w_cmd_my;
               r_seg_cnt  <= SEG_LAST;
               r_state    <= S_RUN;
            end
            S_RUN: begin
               if (r_seg_cnt == 16'd0) begin
                  if (r_count != 3'd0) begin
                     r_state <= S_LOAD;
                  end else begin
                     r_state    <= S_HOLD;
                     r_idle_cnt <= 16'd0;
                  end
               end else begin
                  r_seg_cnt <= r_seg_cnt - 16'd1;
               end
            end
            default: begin
               if (r_count != 3'd0) begin
                  r_state <= S_LOAD;
               end else if (r_idle_cnt == IDLE_LAST) begin
                  r_state <= S_AUTO;
                  r_auto  <= 1'b1;
                  if (r_motion_x == 10'd0)
                     r_motion_x <= STEP;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 16'd1;
               end
            end
         endcase

         // Wall bounce is written last so it wins over any command load.
         if (w_x_hi)
            r_motion_x <= NEG_STEP;
         else if (w_x_lo)
            r_motion_x <= STEP;
         if (w_y_hi)
            r_motion_y <= NEG_STEP;
         else if (w_y_lo)
            r_motion_y <= STEP;
      end
   end

   assign bus.MotionX    = r_motion_x;
   assign bus.MotionY    = r_motion_y;
   assign bus.auto_mode  = r_auto;
   assign bus.fifo_count = r_count;
   assign bus.overflow   = r_overflow;

endmodule

// File: doc/ball_move_sched.md
BALL_MOVE_SCHED -- requirements
Module: ball_move_sched

Interface
REQ-001 The module SHALL have parameter STEP, default 10'd1, motion magnitude per frame.
REQ-002 The module SHALL have parameter SEG_LEN, default 16, frames executed per queued command.
REQ-003 The module SHALL have parameter IDLE_TIMEOUT, default 300, idle frames before reverting to autopilot.
REQ-004 The module SHALL have parameters X_MIN 0, X_MAX 639, Y_MIN 0, Y_MAX 479, screen bounds.
REQ-005 Port: frame_clk  input  1  frame-rate clock; all state updates on its rising edge.
REQ-006 Port: Reset  input  1  synchronous, active-high reset.
REQ-007 Port: keycode  input  8  USB HID keycode, 8'h00 = no key.
REQ-008 Port: BallX, BallY  input  10 each  current ball centre.
REQ-009 Port: BallS  input  10  ball half-size.
REQ-010 Port: MotionX, MotionY  output  10 each  registered two's-complement per-frame motion for the ball datapath.
REQ-011 Port: auto_mode  output  1  high while in AUTO state.
REQ-012 Port: fifo_count  output  3  queued commands, 0..4.
REQ-013 Port: overflow  output  1  sticky flag, a command was dropped.

Function
REQ-014 Valid codes SHALL map: 8'h1A up (Y=-STEP, X=0), 8'h16 down (Y=+STEP, X=0), 8'h04 left (X=-STEP, Y=0), 8'h07 right (X=+STEP, Y=0); all others ignored.
REQ-015 A push SHALL occur only when keycode is valid and differs from key_prev (keycode registered every frame); a held key pushes once.
REQ-016 Command FIFO SHALL be 4 entries, 2-bit encoded, first-in first-out, pointers wrapping modulo 4.
REQ-017 Push while full with no pop SHALL be dropped and SHALL set overflow, which stays set until Reset.
REQ-018 Simultaneous push and pop SHALL both take effect, including when full (no drop) and when empty is impossible (pop requires non-empty).
REQ-019 FSM states SHALL be AUTO, LOAD, RUN, HOLD.
REQ-020 AUTO: motion retained except wall bounce; fifo_count>0 -> LOAD next frame.
REQ-021 LOAD: pop head, load MotionX/MotionY from command, seg_cnt <= SEG_LEN-1, -> RUN; new motion visible one frame after entering LOAD.
REQ-022 RUN: seg_cnt decrements each frame; at seg_cnt==0 -> LOAD if fifo non-empty, else HOLD with idle_cnt <= 0.
REQ-023 HOLD: motion retained, idle_cnt increments; fifo non-empty -> LOAD (priority); idle_cnt==IDLE_TIMEOUT-1 -> AUTO with MotionX=+STEP if MotionX==0, MotionY unchanged.
REQ-024 Wall override SHALL apply in every state, each axis independently, after command load, taking priority: BallY+BallS>=Y_MAX -> MotionY=-STEP; BallY<=Y_MIN+BallS -> MotionY=+STEP; same for X with X bounds.
REQ-025 Comparisons SHALL use 11-bit unsigned arithmetic so BallX+BallS never wraps and no subtraction underflows.
REQ-026 Key presses arriving during LOAD/RUN SHALL queue and never interrupt the current segment.

Reset
REQ-027 On Reset: state AUTO, MotionX=STEP, MotionY=0, auto_mode=1, FIFO empty, fifo_count=0, overflow=0, key_prev=0, seg_cnt=0, idle_cnt=0.
REQ-028 Reset mid-operation SHALL discard queued commands and counters in the same frame.

Verification
REQ-029 Reset, ball at (320,240), keycode 0 for 5 frames -> MotionX=1, MotionY=0, auto_mode=1, fifo_count=0.
REQ-030 keycode 8'h1A held 40 frames -> exactly one push; LOAD frame 2, MotionY=-1 frame 3, 16 frames RUN, then HOLD, auto_mode=0.
REQ-031 Pulses 04,07,16,1A,04 (0 between) during RUN -> fifo_count reaches 4, fifth dropped, overflow=1, commands execute in order left,right,down,up.
REQ-032 RUN with MotionY=+1, BallY=464, BallS=16 -> MotionY=-1 next frame despite command; BallX=16 -> MotionX=+1 same frame (both axes).
REQ-033 HOLD with empty FIFO for 300 frames -> AUTO, auto_mode=1, MotionX=+1 if previously 0.
REQ-034 Reset asserted with fifo_count=3 in RUN -> next frame all outputs at REQ-027 values.
